// File: rtl/fft_sched_pkg.sv
// Shared types and helpers for the FFT stage sequencer.
package fft_sched_pkg;

  localparam int STAGE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Butterfly stride for a stage: 1, 2, 4, ...
  function automatic logic [15:0] stage_step(input logic [STAGE_W-1:0] stage);
    return 16'(1) << stage;
  endfunction

endpackage

// File: rtl/fft_beat_counter.sv
// Beat counter for one stage; wraps to 0 on the last beat so it never exceeds FRAME_LEN-1.
module fft_beat_counter
  import fft_sched_pkg::*;
#(
  parameter int LOG2_N = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = LOG2_N + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'((1 << LOG2_N) - 1);

  logic [CW-1:0] count_q, count_d;

  assign last = en && (count_q == LAST_BEAT);

  always_comb begin
    count_d = count_q;
    if (clr || last) count_d = '0;
    else if (en)     count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/fft_stage_sched.sv
// Stage sequencer: walks one counter_d instance through LOG2_N butterfly stages per frame.
module fft_stage_sched
  import fft_sched_pkg::*;
#(
  parameter int LOG2_N     = 9,
  parameter int CNT_WIDTH  = 36,
  parameter int STEP_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  din_valid,
  output logic                  cnt_ena,
  output logic                  cnt_rst,
  output logic                  cnt_updown,
  output logic [STEP_WIDTH-1:0] cnt_step,
  output logic [CNT_WIDTH-1:0]  cnt_min,
  output logic [CNT_WIDTH-1:0]  cnt_max,
  output logic [3:0]            stage,
  output logic                  stage_first,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CNT_WIDTH-1:0] MAX_VAL    = CNT_WIDTH'((1 << LOG2_N) - 1);
  localparam logic [STAGE_W-1:0]   LAST_STAGE = STAGE_W'(LOG2_N - 1);

  state_e                  state_q, state_d;
  logic [STAGE_W-1:0]      stage_q, stage_d;
  logic [STEP_WIDTH-1:0]   cnt_step_q, cnt_step_d;
  logic                    cnt_updown_q, cnt_updown_d;
  logic [CNT_WIDTH-1:0]    cnt_min_q, cnt_min_d;
  logic [CNT_WIDTH-1:0]    cnt_max_q, cnt_max_d;
  logic                    first_q, first_d;
  logic                    load_cfg;
  logic                    beat_en, beat_clr, beat_last;

  assign beat_en  = (state_q == ST_RUN) && din_valid;
  assign beat_clr = (state_q != ST_RUN) || abort;

  fft_beat_counter #(.LOG2_N(LOG2_N)) u_beat (
    .clk  (clk),
    .rst  (rst),
    .clr  (beat_clr),
    .en   (beat_en),
    .last (beat_last)
  );

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    load_cfg = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_LOAD;
        stage_d  = '0;
        load_cfg = 1'b1;
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: if (beat_last) begin
        if (stage_q < LAST_STAGE) begin
          state_d  = ST_LOAD;
          stage_d  = stage_q + STAGE_W'(1);
          load_cfg = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over start and over last-beat advances; config is left as-is.
    if (abort) begin
      state_d  = ST_IDLE;
      stage_d  = '0;
      load_cfg = 1'b0;
    end
  end

  // Config only moves on the edge that enters LOAD, so it is frozen through RUN.
  always_comb begin
    cnt_step_d   = cnt_step_q;
    cnt_updown_d = cnt_updown_q;
    cnt_min_d    = cnt_min_q;
    cnt_max_d    = cnt_max_q;
    if (load_cfg) begin
      cnt_step_d   = STEP_WIDTH'(stage_step(stage_d));
      cnt_updown_d = ~stage_d[0];
      cnt_min_d    = '0;
      cnt_max_d    = MAX_VAL;
    end
    first_d = (state_q == ST_LOAD) && (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      stage_q      <= '0;
      cnt_step_q   <= STEP_WIDTH'(1);
      cnt_updown_q <= 1'b1;
      cnt_min_q    <= '0;
      cnt_max_q    <= MAX_VAL;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      cnt_step_q   <= cnt_step_d;
      cnt_updown_q <= cnt_updown_d;
      cnt_min_q    <= cnt_min_d;
      cnt_max_q    <= cnt_max_d;
      first_q      <= first_d;
    end
  end

  assign cnt_rst     = (state_q != ST_RUN);
  assign cnt_ena     = beat_en;
  assign cnt_step    = cnt_step_q;
  assign cnt_updown  = cnt_updown_q;
  assign cnt_min     = cnt_min_q;
  assign cnt_max     = cnt_max_q;
  assign stage       = stage_q;
  assign stage_first = first_q;
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_fft_stage_sched.sv
// Directed bench for fft_stage_sched at LOG2_N=4, plus a full-length LOG2_N=9 frame.
module tb_fft_stage_sched;

  logic        clk = 1'b0;
  logic        rst, start, abort, din_valid;
  logic        cnt_ena, cnt_rst, cnt_updown, stage_first, busy, done;
  logic [8:0]  cnt_step;
  logic [35:0] cnt_min, cnt_max;
  logic [3:0]  stage;

  logic        start9, abort9, din9;
  logic        ena9, crst9, updown9, first9, busy9, done9;
  logic [8:0]  step9;
  logic [35:0] min9, max9;
  logic [3:0]  stage9;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fft_stage_sched #(.LOG2_N(4), .CNT_WIDTH(36), .STEP_WIDTH(9)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .din_valid(din_valid),
    .cnt_ena(cnt_ena), .cnt_rst(cnt_rst), .cnt_updown(cnt_updown), .cnt_step(cnt_step),
    .cnt_min(cnt_min), .cnt_max(cnt_max), .stage(stage), .stage_first(stage_first),
    .busy(busy), .done(done)
  );

  fft_stage_sched #(.LOG2_N(9), .CNT_WIDTH(36), .STEP_WIDTH(9)) u_dut9 (
    .clk(clk), .rst(rst), .start(start9), .abort(abort9), .din_valid(din9),
    .cnt_ena(ena9), .cnt_rst(crst9), .cnt_updown(updown9), .cnt_step(step9),
    .cnt_min(min9), .cnt_max(max9), .stage(stage9), .stage_first(first9),
    .busy(busy9), .done(done9)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; din_valid = 1'b0;
    start9 = 1'b0; abort9 = 1'b0; din9 = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1; start = 1'b0; din_valid = 1'b0;
    tick();
    abort = 1'b0;
  endtask

  int nload, nena, ndone, nrun, nfirst, done_at;

  initial begin
    // 1: idle after reset
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("s1_cnt_rst", cnt_rst, 1);
      chk("s1_busy", busy, 0);
      chk("s1_step", cnt_step, 1);
      chk("s1_max", cnt_max, 15);
      chk("s1_updown", cnt_updown, 1);
      tick();
    end
    chk("s1_min", cnt_min, 0);
    chk("s1_done", done, 0);
    chk("s1_ena", cnt_ena, 0);

    // 2: full frame, din_valid held high
    do_reset();
    nload = 0; nena = 0; ndone = 0;
    for (int c = 0; c < 75; c++) begin
      start = (c == 0); din_valid = 1'b1;
      @(negedge clk);
      if (busy && cnt_rst) begin
        chk("s2_load_cyc", c, 1 + 17 * nload);
        chk("s2_step", cnt_step, 1 << nload);
        chk("s2_updown", cnt_updown, (nload % 2 == 0));
        chk("s2_stage", stage, nload);
        nload++;
      end
      if (cnt_ena) nena++;
      if (done) begin
        ndone++;
        chk("s2_done_cyc", c, 69);
        chk("s2_busy_at_done", busy, 0);
      end
      tick();
    end
    chk("s2_nload", nload, 4);
    chk("s2_ndone", ndone, 1);
    chk("s2_nena", nena, 64);

    // 3: din_valid toggling in stage 0
    do_reset();
    nrun = 0; nena = 0; nfirst = 0;
    for (int c = 0; c < 40; c++) begin
      start = (c == 0); din_valid = (c % 2 == 1);
      @(negedge clk);
      if (busy && !cnt_rst && stage == 0) begin
        nrun++;
        if (cnt_ena) nena++;
        if (stage_first) nfirst++;
      end
      tick();
    end
    chk("s3_run_cycles", nrun, 32);
    chk("s3_ena", nena, 16);
    chk("s3_first", nfirst, 1);
    do_abort();

    // 4: abort on the last beat of stage 2
    do_reset();
    ndone = 0;
    for (int c = 0; c < 52; c++) begin
      start = (c == 0); din_valid = 1'b1; abort = (c == 51);
      @(negedge clk);
      if (done) ndone++;
      if (c == 51) begin
        chk("s4_stage_pre", stage, 2);
        chk("s4_ena_pre", cnt_ena, 1);
      end
      tick();
    end
    abort = 1'b0;
    for (int c = 52; c < 56; c++) begin
      @(negedge clk);
      if (done) ndone++;
      if (c == 52) begin
        chk("s4_busy", busy, 0);
        chk("s4_stage", stage, 0);
        chk("s4_cnt_rst", cnt_rst, 1);
      end
      tick();
    end
    chk("s4_no_done", ndone, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("s4_restart_busy", busy, 1);
    chk("s4_restart_stage", stage, 0);
    chk("s4_restart_load", cnt_rst, 1);
    chk("s4_restart_step", cnt_step, 1);
    tick();
    @(negedge clk);
    chk("s4_restart_first", stage_first, 1);
    chk("s4_restart_run", cnt_rst, 0);
    do_abort();

    // 5: start pulses during RUN and DONE are ignored
    do_reset();
    ndone = 0; done_at = -1;
    for (int c = 0; c < 76; c++) begin
      start = (c == 0 || c == 10 || c == 30 || c == 69); din_valid = 1'b1;
      @(negedge clk);
      if (done) begin ndone++; done_at = c; end
      if (c == 10) chk("s5_stage_c10", stage, 0);
      if (c == 70) chk("s5_busy_c70", busy, 0);
      if (c == 71) chk("s5_busy_c71", busy, 0);
      tick();
    end
    chk("s5_ndone", ndone, 1);
    chk("s5_done_cyc", done_at, 69);

    // 6: reset mid-stage 1
    do_reset();
    for (int c = 0; c < 26; c++) begin
      start = (c == 0); din_valid = 1'b1; rst = (c == 25);
      @(negedge clk);
      if (c == 25) chk("s6_stage_pre", stage, 1);
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("s6_cnt_rst", cnt_rst, 1);
    chk("s6_busy", busy, 0);
    chk("s6_stage", stage, 0);
    chk("s6_step", cnt_step, 1);
    chk("s6_updown", cnt_updown, 1);
    chk("s6_max", cnt_max, 15);
    chk("s6_min", cnt_min, 0);
    chk("s6_ena", cnt_ena, 0);
    chk("s6_first", stage_first, 0);
    chk("s6_done", done, 0);
    din_valid = 1'b0;

    // 6b: full LOG2_N=9 frame
    do_reset();
    ndone = 0; done_at = -1;
    for (int c = 0; c < 4630; c++) begin
      start9 = (c == 0); din9 = 1'b1;
      @(negedge clk);
      if (done9) begin
        ndone++; done_at = c;
        chk("s6b_step", step9, 256);
        chk("s6b_stage", stage9, 8);
        chk("s6b_max", max9, 511);
        chk("s6b_busy", busy9, 0);
      end
      tick();
    end
    chk("s6b_ndone", ndone, 1);
    chk("s6b_done_cyc", done_at, 4618);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_stage_sched.md
# fft_stage_sched

Stage sequencer for the Biplex FFT address path. It configures and drives one `counter_d` instance through the `LOG2_N` butterfly stages of one FFT frame: load the stage stride and direction, run exactly one frame of valid beats, advance to the next stage, then signal completion. It sits between the frame-level control (`start`/`abort`) and the `counter_d` configuration inputs, whose port widths it matches.

## Interface
- `LOG2_N`, default 9: log2 of the frame length. Legal range is 2..9. `FRAME_LEN = 2**LOG2_N`.
- `CNT_WIDTH`, default 36: width of `cnt_min` and `cnt_max`.
- `STEP_WIDTH`, default 9: width of `cnt_step`.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle frame start request. Honoured only in IDLE.
- `abort` in 1: synchronous abort from any state.
- `din_valid` in 1: data beat valid. Advances the counter in RUN.
- `cnt_ena` out 1: counter enable.
- `cnt_rst` out 1: counter reset, which holds the counter at MIN.
- `cnt_updown` out 1: counter direction. 1 = up, 0 = down.
- `cnt_step` out STEP_WIDTH: counter stride.
- `cnt_min` out CNT_WIDTH: counter lower bound.
- `cnt_max` out CNT_WIDTH: counter upper bound.
- `stage` out 4: current stage index, 0..LOG2_N-1.
- `stage_first` out 1: high on the first RUN cycle of each stage.
- `busy` out 1: high in LOAD and RUN.
- `done` out 1: one-cycle frame-complete pulse.

## Operation
States and transitions:
- IDLE: `start` moves to LOAD with `stage` = 0.
- LOAD: always moves to RUN after 1 cycle.
- RUN: a beat is counted when `din_valid` = 1. On the last beat (beat = FRAME_LEN-1 with `din_valid`):
  - if `stage` < LOG2_N-1, move to LOAD and increment `stage`;
  - otherwise move to DONE.
- DONE: always moves to IDLE after 1 cycle.
- `abort`, in any state: next state is IDLE, beat counter and `stage` clear to 0, no `done`. `abort` has priority over `start` and over last-beat transitions.

Stage configuration, registered and updated on entry to LOAD:
- `cnt_step` = 1 << stage.
- `cnt_updown` = ~stage[0]: even stages count up, odd stages count down (ping-pong buffer).
- `cnt_min` = 0.
- `cnt_max` = FRAME_LEN-1, zero-extended to CNT_WIDTH.

Outputs:
- `cnt_rst` = 1 in IDLE, LOAD and DONE. This is a Moore decode of the registered state.
- `cnt_ena` = (state == RUN) & `din_valid`. This is combinational from `din_valid`, zero latency.
- Beat counter: LOG2_N+1 bits. Cleared in LOAD. Increments only on `din_valid` in RUN. It never exceeds FRAME_LEN-1.
- `start` while busy or in DONE is ignored. It is not queued.

Reset state:
- State IDLE, `stage` = 0, beat counter = 0.
- `cnt_step` = 1, `cnt_updown` = 1, `cnt_min` = 0, `cnt_max` = FRAME_LEN-1.
- `busy`, `done`, `stage_first`, `cnt_ena` = 0. `cnt_rst` = 1.
- `rst` mid-frame has the same effect as `abort`, plus a config reload.

## Timing
- `start` sampled at cycle t: LOAD at t+1 (`busy`=1, `stage`=0), RUN at t+2.
- `stage_first`:
  - is high on the RUN entry cycle regardless of `din_valid`;
  - is not retriggered by stalls.
- Each stage is 1 LOAD cycle plus at least FRAME_LEN RUN cycles. Gaps in `din_valid` stretch RUN cycle-for-cycle.
- With `din_valid` held at 1, `done` is at cycle t + LOG2_N·(FRAME_LEN+1) + 1. `busy` falls on that same cycle.
- Config outputs change only on the cycle LOAD is entered. They are stable throughout RUN.
- Back-to-back frames: `start` asserted in the DONE cycle is ignored. The earliest accepted `start` is in the following IDLE cycle.

## Structure
- Package `fft_sched_pkg` holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - `STAGE_W` = 4;
  - a function `stage_step(stage)`.
- One sub-module, `fft_beat_counter`: beat counter with clear, enable, and a `last` flag (count == FRAME_LEN-1 & en).
- FSM and configuration registers live in the top level. `counter_d` is instantiated by the parent, not inside this block.

## Test plan
All scenarios use LOG2_N=4 unless stated.
1. Reset, then idle for 5 cycles: `cnt_rst`=1, `busy`=0, `cnt_step`=1, `cnt_max`=15, `cnt_updown`=1 throughout.
2. `start` at cycle 0 with `din_valid`=1 continuously:
   - LOAD at cycles 1, 18, 35, 52;
   - `cnt_step` takes 1, 2, 4, 8;
   - `cnt_updown` takes 1, 0, 1, 0;
   - `done` pulses at cycle 69 only;
   - total `cnt_ena` count = 64.
3. `din_valid` toggling 1,0 in stage 0: stage 0 RUN lasts 32 cycles, 16 `cnt_ena` pulses, `stage_first` high once.
4. `abort` on the last beat of stage 2: IDLE next cycle, `stage`=0, no `done`, `cnt_rst`=1. A new `start` is then accepted normally.
5. `start` pulsed during RUN and during DONE: no effect. The frame completes with exactly one `done`.
6. `rst` asserted mid-stage 1: outputs equal the reset values the following cycle. Repeat scenario 2 with LOG2_N=9: `done` at cycle 4618, final `cnt_step`=256.
